// File: rtl/intc_pkg.sv
// Shared constants for the external interrupt controller: register offsets,
// default bus base address and the width of the core's hard interrupt input.
`default_nettype none

package intc_pkg;
  localparam int          CPU_N_HARD_INT   = 6;
  localparam logic [31:0] INTC_BASE        = 32'h0000_7F40;

  typedef logic [3:0] intc_off_t;

  localparam intc_off_t   INTC_OFF_RAW     = 4'h0;
  localparam intc_off_t   INTC_OFF_PENDING = 4'h4;
  localparam intc_off_t   INTC_OFF_MASK    = 4'h8;
  localparam intc_off_t   INTC_OFF_MODE    = 4'hC;

  // Word-aligned register offset; byte-lane bits are ignored.
  function automatic intc_off_t intc_reg_off(input logic [3:0] addr_lo);
    return {addr_lo[3:2], 2'b00};
  endfunction
endpackage

`default_nettype wire

// File: rtl/int_sync.sv
// Multi-stage flip-flop synchroniser for asynchronous interrupt sources.
`default_nettype none

module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/intc.sv
// External interrupt controller: synchronises sources, latches edge/level
// requests, masks them and drives the core's registered hard_int lines.
`default_nettype none

module intc
  import intc_pkg::*;
#(
  parameter int          N_SRC       = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = INTC_BASE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          irq_src,
  input  logic                      bus_wr,
  input  logic                      bus_rd,
  input  logic [31:0]               bus_addr,
  input  logic [31:0]               bus_wdata,
  output logic [31:0]               bus_rdata,
  output logic [CPU_N_HARD_INT-1:0] hard_int
);

  logic [N_SRC-1:0] sync_out;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;

  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] mask_next;
  logic [N_SRC-1:0] mode_next;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] w1c;
  logic [CPU_N_HARD_INT-1:0] hard_next;

  logic      hit;
  intc_off_t off;
  logic      wr_pending;
  logic      wr_mask;
  logic      wr_mode;
  logic      unused_bus_bits;

  int_sync #(
    .WIDTH  (N_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_src),
    .q   (sync_out)
  );

  assign hit        = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off        = intc_reg_off(bus_addr[3:0]);
  assign wr_pending = bus_wr && hit && (off == INTC_OFF_PENDING);
  assign wr_mask    = bus_wr && hit && (off == INTC_OFF_MASK);
  assign wr_mode    = bus_wr && hit && (off == INTC_OFF_MODE);

  assign unused_bus_bits = ^{bus_addr[1:0], bus_wdata};

  // Pending uses the current MODE so a mode change only alters behaviour from
  // the following cycle; a fresh edge always wins over a same-cycle W1C.
  always_comb begin
    mask_next    = wr_mask ? bus_wdata[N_SRC-1:0] : mask;
    mode_next    = wr_mode ? bus_wdata[N_SRC-1:0] : mode;
    edge_set     = s & ~prev;
    w1c          = wr_pending ? bus_wdata[N_SRC-1:0] : '0;
    pending_next = (mode & (edge_set | (pending & ~w1c))) | (~mode & s);
    hard_next    = '0;
    hard_next[N_SRC-1:0] = pending_next & mask_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s        <= '0;
      prev     <= '0;
      pending  <= '0;
      mask     <= '0;
      mode     <= '1;
      hard_int <= '0;
    end else begin
      s        <= sync_out;
      prev     <= s;
      pending  <= pending_next;
      mask     <= mask_next;
      mode     <= mode_next;
      hard_int <= hard_next;
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_rd && hit) begin
      case (off)
        INTC_OFF_RAW:     bus_rdata[N_SRC-1:0] = s;
        INTC_OFF_PENDING: bus_rdata[N_SRC-1:0] = pending;
        INTC_OFF_MASK:    bus_rdata[N_SRC-1:0] = mask;
        INTC_OFF_MODE:    bus_rdata[N_SRC-1:0] = mode;
        default:          bus_rdata = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intc.sv
// Directed self-checking bench for the interrupt controller.
`default_nettype none

module tb_intc;
  localparam int          SS        = 2;
  localparam logic [31:0] BASE      = 32'h0000_7F40;
  localparam logic [31:0] A_RAW     = BASE + 32'h0;
  localparam logic [31:0] A_PENDING = BASE + 32'h4;
  localparam logic [31:0] A_MASK    = BASE + 32'h8;
  localparam logic [31:0] A_MODE    = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  irq_src = '0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [5:0]  hard_int;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;

  intc #(.N_SRC(6), .SYNC_STAGES(SS), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .hard_int  (hard_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_rd   = 1'b1;
    #1;
    d        = bus_rdata;
    bus_rd   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL reset_hard_int got %h want 00", hard_int); end
    rst = 1'b1;
    tick();
    bus_read(A_MODE, rv);
    checks++;
    if (rv !== 32'h3F) begin errors++; $display("FAIL reset_mode got %h want 3f", rv); end
    bus_read(A_MASK, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", rv); end
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", rv); end
    checks++;
    if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_idle got %h want 0", bus_rdata); end
  endtask

  task automatic test_edge();
    bus_write(A_MASK, 32'h01);
    irq_src[0] = 1'b1;
    repeat (SS + 1) tick();
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL edge_early got %h want 00", hard_int); end
    irq_src[0] = 1'b0;
    tick();
    checks++;
    if (hard_int !== 6'h01) begin errors++; $display("FAIL edge_latency got %h want 01", hard_int); end
    repeat (5) tick();
    checks++;
    if (hard_int !== 6'h01) begin errors++; $display("FAIL edge_sticky got %h want 01", hard_int); end
    bus_write(A_PENDING, 32'h01);
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL edge_w1c got %h want 00", hard_int); end
  endtask

  task automatic test_collision();
    irq_src[2] = 1'b1;
    repeat (SS + 1) tick();
    bus_write(A_PENDING, 32'h04);
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h04) begin errors++; $display("FAIL collision_pending got %h want 04", rv); end
    irq_src[2] = 1'b0;
    bus_write(A_PENDING, 32'h04);
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h00) begin errors++; $display("FAIL collision_clear got %h want 00", rv); end
  endtask

  task automatic test_level();
    bus_write(A_MODE, 32'h3D);
    bus_write(A_MASK, 32'h02);
    irq_src[1] = 1'b1;
    repeat (SS + 2) tick();
    checks++;
    if (hard_int !== 6'h02) begin errors++; $display("FAIL level_set got %h want 02", hard_int); end
    bus_write(A_PENDING, 32'h02);
    checks++;
    if (hard_int !== 6'h02) begin errors++; $display("FAIL level_w1c_ignored got %h want 02", hard_int); end
    irq_src[1] = 1'b0;
    repeat (SS) tick();
    checks++;
    if (hard_int !== 6'h02) begin errors++; $display("FAIL level_drop_early got %h want 02", hard_int); end
    repeat (2) tick();
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL level_drop got %h want 00", hard_int); end
    bus_write(A_MODE, 32'h3F);
  endtask

  task automatic test_mask_readback();
    bus_write(A_MASK, 32'h00);
    irq_src = 6'h3F;
    repeat (SS + 3) tick();
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL masked_hard_int got %h want 00", hard_int); end
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h3F) begin errors++; $display("FAIL masked_pending got %h want 3f", rv); end
    bus_read(A_RAW, rv);
    checks++;
    if (rv !== 32'h3F) begin errors++; $display("FAIL raw_read got %h want 3f", rv); end
    bus_write(A_MASK, 32'h24);
    checks++;
    if (hard_int !== 6'h24) begin errors++; $display("FAIL mask_write got %h want 24", hard_int); end
    bus_read(BASE + 32'h10, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", rv); end
    bus_addr = A_MASK;
    bus_rd   = 1'b0;
    #1;
    checks++;
    if (bus_rdata !== 32'h0) begin errors++; $display("FAIL read_disabled got %h want 0", bus_rdata); end
  endtask

  task automatic test_async_reset();
    bus_write(A_MASK, 32'h3F);
    checks++;
    if (hard_int !== 6'h3F) begin errors++; $display("FAIL pre_reset_hard_int got %h want 3f", hard_int); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL async_reset_hard_int got %h want 00", hard_int); end
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL async_reset_pending got %h want 0", rv); end
    bus_read(A_MODE, rv);
    checks++;
    if (rv !== 32'h3F) begin errors++; $display("FAIL async_reset_mode got %h want 3f", rv); end
    repeat (2) tick();
    rst = 1'b1;
    repeat (SS + 2) tick();
    bus_read(A_PENDING, rv);
    checks++;
    if (rv !== 32'h3F) begin errors++; $display("FAIL release_edge_pending got %h want 3f", rv); end
    checks++;
    if (hard_int !== 6'h00) begin errors++; $display("FAIL release_hard_int got %h want 00", hard_int); end
    irq_src = 6'h00;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_collision();
    test_level();
    test_mask_readback();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
